// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and size helpers.
package mem_pkg;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

   typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, ERR, RESP} state_e;

   localparam int BYTE_W = 8;

   function automatic logic [3:0] size_bytes(input size_e sz);
      return 4'b0001 << sz;
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering between a 64-bit memory word and a sub-word access:
// extended load extraction and read-modify-write merge.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [63:0] i_word,
   input  logic [2:0]  i_lane,
   input  size_e       i_size,
   input  logic        i_signed,
   input  logic [63:0] i_wdata,
   output logic [63:0] o_load,
   output logic [63:0] o_merged
);

   logic [63:0] w_shifted;
   logic [63:0] w_wshift;
   logic [3:0]  w_nbytes;
   logic [3:0]  w_lane_end;
   logic [7:0]  w_bmask;

   assign w_shifted  = i_word >> {i_lane, 3'b000};
   assign w_wshift   = i_wdata << {i_lane, 3'b000};
   assign w_nbytes   = size_bytes(i_size);
   assign w_lane_end = {1'b0, i_lane} + w_nbytes;

   always_comb begin
      o_load = w_shifted;
      case (i_size)
         SZ_B:    o_load = {{56{i_signed & w_shifted[7]}},  w_shifted[7:0]};
         SZ_H:    o_load = {{48{i_signed & w_shifted[15]}}, w_shifted[15:0]};
         SZ_W:    o_load = {{32{i_signed & w_shifted[31]}}, w_shifted[31:0]};
         default: o_load = w_shifted;
      endcase
   end

   // Bytes inside [lane, lane+nbytes) come from the store data, the rest from memory.
   for (genvar gi = 0; gi < 8; gi++) begin : g_byte
      assign w_bmask[gi] = ({1'b0, i_lane} <= 4'(gi)) && (4'(gi) < w_lane_end);
      assign o_merged[gi*BYTE_W +: BYTE_W] = w_bmask[gi] ? w_wshift[gi*BYTE_W +: BYTE_W]
                                                         : i_word[gi*BYTE_W +: BYTE_W];
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns byte/half/word/dword requests into aligned 8-byte
// memory accesses, with read-modify-write for sub-word stores.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int MEM_BYTES = 32,
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              stall,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_datain,
   output logic              mem_w,
   output logic              mem_r,
   input  logic [DATA_W-1:0] mem_dataout
);

   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

   state_e            r_state;
   logic [2:0]        r_lane;
   size_e             r_size;
   logic              r_signed;
   logic [DATA_W-1:0] r_wdata;
   logic              r_resp_valid;
   logic              r_resp_err;
   logic [DATA_W-1:0] r_resp_rdata;
   logic [ADDR_W-1:0] r_mem_adr;
   logic [DATA_W-1:0] r_mem_datain;
   logic              r_mem_w;
   logic              r_mem_r;

   size_e             w_size;
   logic [3:0]        w_nbytes;
   logic [ADDR_W-1:0] w_base;
   logic [ADDR_W:0]   w_end;
   logic              w_misaligned;
   logic              w_err;
   logic [DATA_W-1:0] w_load_val;
   logic [DATA_W-1:0] w_merged;

   assign w_size       = size_e'(req_size);
   assign w_nbytes     = size_bytes(w_size);
   assign w_base       = {req_addr[ADDR_W-1:3], 3'b000};
   // One extra bit so addresses near the top of the space cannot wrap back into range.
   assign w_end        = {1'b0, req_addr} + {{(ADDR_W-3){1'b0}}, w_nbytes};
   assign w_misaligned = |(req_addr[2:0] & ~(3'b111 << req_size));
   assign w_err        = w_misaligned || (w_end > MEM_LIMIT);

   mem_lane_align u_align (
      .i_word   (mem_dataout),
      .i_lane   (r_lane),
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_wdata  (r_wdata),
      .o_load   (w_load_val),
      .o_merged (w_merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_lane       <= '0;
         r_size       <= SZ_B;
         r_signed     <= 1'b0;
         r_wdata      <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
         r_mem_adr    <= '0;
         r_mem_datain <= '0;
         r_mem_w      <= 1'b0;
         r_mem_r      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (req_valid) begin
               r_lane   <= req_addr[2:0];
               r_size   <= w_size;
               r_signed <= req_signed;
               r_wdata  <= req_wdata;
               if (w_err) begin
                  r_state <= ERR;
               end else if (!req_write) begin
                  r_state   <= LOAD;
                  r_mem_r   <= 1'b1;
                  r_mem_adr <= w_base;
               end else if (w_size == SZ_D) begin
                  r_state      <= WRITE;
                  r_mem_w      <= 1'b1;
                  r_mem_adr    <= w_base;
                  r_mem_datain <= req_wdata;
               end else begin
                  r_state   <= RMW_READ;
                  r_mem_r   <= 1'b1;
                  r_mem_adr <= w_base;
               end
            end
            LOAD: begin
               r_resp_rdata <= w_load_val;
               r_resp_valid <= 1'b1;
               r_mem_r      <= 1'b0;
               r_mem_adr    <= '0;
               r_state      <= RESP;
            end
            RMW_READ: begin
               r_mem_r      <= 1'b0;
               r_mem_w      <= 1'b1;
               r_mem_datain <= w_merged;
               r_state      <= WRITE;
            end
            WRITE: begin
               r_mem_w      <= 1'b0;
               r_mem_adr    <= '0;
               r_mem_datain <= '0;
               r_resp_valid <= 1'b1;
               r_state      <= RESP;
            end
            ERR: begin
               r_resp_err   <= 1'b1;
               r_resp_rdata <= '0;
               r_resp_valid <= 1'b1;
               r_state      <= RESP;
            end
            RESP: begin
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
               r_resp_rdata <= '0;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready  = (r_state == IDLE);
   assign stall      = (r_state != IDLE);
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign resp_rdata = r_resp_rdata;
   assign mem_adr    = r_mem_adr;
   assign mem_datain = r_mem_datain;
   assign mem_w      = r_mem_w;
   assign mem_r      = r_mem_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed checks of mem_access_unit against a byte-array reference model.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic [63:0] req_addr = 64'd0;
   logic [63:0] req_wdata = 64'd0;
   logic        req_ready, stall, resp_valid, resp_err, mem_w, mem_r;
   logic [63:0] resp_rdata, mem_adr, mem_datain, mem_dataout;

   // Environment memory seen by the DUT (4 x 64-bit words).
   logic [63:0] env_mem [0:3] = '{default: 64'd0};
   // Reference model memory, byte addressed.
   logic [7:0]  ref_mem [0:31] = '{default: 8'd0};

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.MEM_BYTES(32), .ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .stall(stall),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_adr(mem_adr), .mem_datain(mem_datain), .mem_w(mem_w), .mem_r(mem_r),
      .mem_dataout(mem_dataout)
   );

   assign mem_dataout = env_mem[mem_adr[4:3]];
   always @(posedge clk) if (mem_w) env_mem[mem_adr[4:3]] <= mem_datain;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
   endtask

   function automatic logic model_err(input logic [1:0] sz, input logic [63:0] addr);
      logic [64:0] end_a;
      int n;
      n = 1 << sz;
      end_a = {1'b0, addr} + 65'(n);
      return (addr % 64'(n) != 0) || (end_a > 65'd32);
   endfunction

   function automatic logic [63:0] model_load(input logic [1:0] sz, input logic sg, input logic [63:0] addr);
      logic [63:0] v;
      int n;
      n = 1 << sz;
      v = 64'd0;
      for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
      if (sg && sz != 2'd3 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
      return v;
   endfunction

   function automatic logic [63:0] model_word(input int base);
      logic [63:0] v;
      v = 64'd0;
      for (int i = 0; i < 8; i++) v = v | (64'(ref_mem[base + i]) << (8 * i));
      return v;
   endfunction

   task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [63:0] addr, input logic [63:0] wd);
      logic        e_err;
      logic [63:0] e_rdata, e_datain, e_base;
      int          e_lat, e_nr, e_nw, lat, nr, nw, n;
      logic        got;
      e_err    = model_err(sz, addr);
      e_rdata  = 64'd0;
      e_datain = 64'd0;
      e_base   = {addr[63:3], 3'b000};
      n        = 1 << sz;
      e_nr     = 0;
      e_nw     = 0;
      e_lat    = 2;
      if (!e_err) begin
         if (!wr) begin
            e_rdata = model_load(sz, sg, addr);
            e_nr = 1;
         end else begin
            for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
            e_datain = model_word(int'(e_base));
            e_nw = 1;
            if (sz != 2'd3) begin
               e_nr  = 1;
               e_lat = 3;
            end
         end
      end
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
      req_addr = addr; req_wdata = wd;
      check("ready_at_accept", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_write = $urandom_range(0, 1); req_size = 2'($urandom);
      req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
      lat = 0; nr = 0; nw = 0; got = 1'b0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         if (mem_r) begin
            nr++;
            check("rd_adr", mem_adr, e_base);
         end
         if (mem_w) begin
            nw++;
            check("wr_adr", mem_adr, e_base);
            check("wr_data", mem_datain, e_datain);
         end
         if (resp_valid) begin
            got = 1'b1;
            check("rdata", resp_rdata, e_rdata);
            check("err", 64'(resp_err), 64'(e_err));
         end
      end
      check("resp_seen", 64'(got), 64'd1);
      check("latency", 64'(lat), 64'(e_lat));
      check("mem_r_cycles", 64'(nr), 64'(e_nr));
      check("mem_w_cycles", 64'(nw), 64'(e_nw));
      $display("req wr=%0d sz=%0d sg=%0d addr=0x%h wdata=0x%h -> rdata=0x%h err=%0d lat=%0d",
               wr, sz, sg, addr, wd, resp_rdata, resp_err, lat);
   endtask

   initial begin
      logic [63:0] addrs [3];
      logic [1:0]  sizes [3];
      logic        sgns  [3];
      logic [63:0] exps  [3];
      int          resp_cyc [$];
      logic        seen_w;

      // Reset state
      #1;
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_mem_w", 64'(mem_w), 64'd0);
      check("rst_mem_r", 64'(mem_r), 64'd0);
      check("rst_mem_adr", mem_adr, 64'd0);
      check("rst_rdata", resp_rdata, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_stall", 64'(stall), 64'd0);

      // Directed sequence
      do_req(1'b1, 2'd3, 1'b0, 64'd8,  64'h8877665544332211);
      do_req(1'b0, 2'd3, 1'b0, 64'd8,  64'd0);
      do_req(1'b0, 2'd0, 1'b1, 64'd15, 64'd0);
      do_req(1'b0, 2'd0, 1'b0, 64'd15, 64'd0);
      do_req(1'b0, 2'd1, 1'b1, 64'd12, 64'd0);
      do_req(1'b0, 2'd2, 1'b1, 64'd12, 64'd0);
      do_req(1'b1, 2'd0, 1'b0, 64'd10, 64'h00000000000000AB);
      do_req(1'b0, 2'd3, 1'b0, 64'd8,  64'd0);
      check("mem_after_rmw", env_mem[1], 64'h8877665544AB2211);
      do_req(1'b0, 2'd1, 1'b0, 64'd9,  64'd0);
      do_req(1'b1, 2'd3, 1'b0, 64'd32, 64'h1234);
      do_req(1'b0, 2'd2, 1'b0, 64'd30, 64'd0);
      do_req(1'b0, 2'd3, 1'b0, 64'd24, 64'd0);
      do_req(1'b0, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0);

      // Reset while the write is pending: no commit, no response
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 64'd8; req_wdata = 64'd0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      seen_w = 1'b0;
      for (int c = 0; c < 10 && !seen_w; c++) begin
         @(negedge clk);
         seen_w = mem_w;
      end
      check("rmw_reached_write", 64'(seen_w), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_mem_w_drop", 64'(mem_w), 64'd0);
      repeat (2) begin
         @(negedge clk);
         check("no_resp_in_reset", 64'(resp_valid), 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("no_resp_after_reset", 64'(resp_valid), 64'd0);
      do_req(1'b0, 2'd3, 1'b0, 64'd8, 64'd0);
      check("mem_kept", env_mem[1], 64'h8877665544AB2211);

      // Back-to-back loads with req_valid held high
      addrs = '{64'd8, 64'd12, 64'd15};
      sizes = '{2'd3, 2'd2, 2'd0};
      sgns  = '{1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 3; k++) exps[k] = model_load(sizes[k], sgns[k], addrs[k]);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0;
      req_size = sizes[0]; req_signed = sgns[0]; req_addr = addrs[0];
      check("b2b_ready0", 64'(req_ready), 64'd1);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         check("b2b_ready", 64'(req_ready), 64'(c % 3 == 0));
         check("b2b_stall", 64'(stall), 64'(c % 3 != 0));
         if (resp_valid) begin
            check("b2b_rdata", resp_rdata, exps[resp_cyc.size() % 3]);
            resp_cyc.push_back(c);
            $display("b2b resp at cycle %0d rdata=0x%h", c, resp_rdata);
         end
         if (c % 3 == 0 && c / 3 < 3) begin
            req_size = sizes[c/3]; req_signed = sgns[c/3]; req_addr = addrs[c/3];
         end
      end
      req_valid = 1'b0;
      check("b2b_count", 64'(resp_cyc.size()), 64'd3);
      for (int k = 0; k < resp_cyc.size() && k < 3; k++)
         check("b2b_cycle", 64'(resp_cyc[k]), 64'(2 + 3 * k));

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         logic [63:0] a;
         a = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7)))
                                         : 64'($urandom_range(0, 35));
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, {$urandom, $urandom});
      end
      for (int w = 0; w < 4; w++) check("final_mem", env_mem[w], model_word(8 * w));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit between the EX/MEM pipeline register and the byte-addressed 64-bit data memory.
- Converts byte, half, word and dword loads/stores into full 8-byte aligned memory accesses.
- Performs sign/zero extension on loads. Performs read-modify-write for sub-word stores.
- Flags misaligned or out-of-range accesses. Holds the pipeline through a stall output while busy.

Parameters:
- MEM_BYTES, 32, memory size in bytes; must be a multiple of 8.
- ADDR_W, 64, address width.
- DATA_W, 64, data width; fixed at 64.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_signed  input  1  sign-extend load result; ignored for dword and for stores.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data; right-justified for sub-word stores.
- req_ready  output  1  unit can accept a request this cycle.
- stall  output  1  high whenever the unit is not IDLE.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_W  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or out-of-range request; valid with resp_valid.
- mem_adr  output  ADDR_W  memory address, always 8-byte aligned.
- mem_datain  output  DATA_W  memory write data.
- mem_w  output  1  memory write enable; write commits at the rising edge.
- mem_r  output  1  memory read enable; memory read is combinational.
- mem_dataout  input  DATA_W  memory read data.

Behaviour:
- Reset (async, rst_n = 0):
  - State = IDLE.
  - resp_valid, resp_err, mem_w, mem_r = 0.
  - resp_rdata, mem_adr, mem_datain = 0.
  - Latched request registers cleared.
  - req_ready = 1 once rst_n is high.
- Derived values:
  - nbytes = 1 << req_size.
  - base = {addr[63:3], 3'b000}.
  - lane = addr[2:0].
- Error condition: addr mod nbytes != 0, or addr + nbytes > MEM_BYTES.
- State IDLE:
  - req_ready = 1, stall = 0.
  - On req_valid: latch the request.
    - Error → ERR.
    - Load → LOAD.
    - Store with size 3 → WRITE; merged data = req_wdata.
    - Store with size < 3 → RMW_READ.
- State LOAD:
  - mem_r = 1, mem_adr = base.
  - Extract nbytes bytes from mem_dataout starting at byte lane (little-endian).
  - Extend: signed → copy the top extracted bit; else zero-fill.
  - Register the result into resp_rdata → RESP.
- State RMW_READ:
  - mem_r = 1, mem_adr = base.
  - Register merged = mem_dataout with bytes [lane .. lane+nbytes-1] replaced by req_wdata[8*nbytes-1:0] → WRITE.
- State WRITE:
  - mem_w = 1, mem_adr = base, mem_datain = merged.
  - Exactly one cycle → RESP.
- State ERR:
  - No mem_r or mem_w. Sets resp_err = 1, resp_rdata = 0 → RESP.
- State RESP:
  - resp_valid = 1 for one cycle; req_ready = 0 → IDLE.
- Latency from the accept edge to the resp_valid cycle:
  - error: 2
  - load: 2
  - dword store: 2
  - sub-word store: 3
- Throughput: one request per latency+1 cycles. A request held valid in RESP is accepted in the following IDLE cycle.
- Outside their active states: mem_r = mem_w = 0, mem_adr = mem_datain = 0.
- req_* inputs are sampled only at accept. Changes while busy are ignored.
- Reset asserted during WRITE: mem_w falls asynchronously, so no write commits. Memory keeps its pre-request contents; no response is issued.
- Reset asserted during any other state: the request is dropped; no response is issued.
- Boundary cases:
  - Dword at MEM_BYTES-8 is legal; dword at MEM_BYTES is an error.
  - addr + nbytes is computed at ADDR_W+1 bits, so addresses near 2^64 cannot wrap into range.

Decomposition:
- Package mem_pkg:
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_D).
  - state_e enum (IDLE, LOAD, RMW_READ, WRITE, ERR, RESP).
  - Byte-width constant 8.
  - Function size_bytes().
- Sub-module mem_lane_align: purely combinational.
  - Inputs: 64-bit word, lane, size, signed flag, store data.
  - Outputs: extended load value and merged store word.
- Top level holds the FSM and registers.

Test Plan:
1. Reset, then store dword 0x8877665544332211 at 8 → mem_w high exactly one cycle with mem_adr = 8, resp_valid at accept+2. Then load dword at 8 → resp_rdata = 0x8877665544332211 at accept+2.
2. Load byte at 15: signed → 0xFFFFFFFFFFFFFF88; unsigned → 0x0000000000000088. Load signed half at 12 → 0x0000000000006655. Load signed word at 12 → 0xFFFFFFFF88776655.
3. Store byte 0xAB at 10 → mem_r one cycle, then mem_w one cycle with mem_datain = 0x8877665544AB2211, resp_valid at accept+3. A following dword load at 8 returns 0x8877665544AB2211.
4. Error cases, each → resp_err = 1 at accept+2, and mem_r and mem_w never asserted:
   - load half at 9 (misaligned)
   - store dword at 32 with MEM_BYTES = 32 (out of range)
   - load word at 30 (out of range)
5. Byte store of 0x00 at 8; assert rst_n = 0 while in WRITE → mem_w drops the same cycle, no resp_valid. After release, load dword at 8 still returns 0x8877665544AB2211.
6. Keep req_valid high with three back-to-back loads → req_ready low and stall high while busy, each load accepted in the IDLE cycle after RESP, and three resp_valid pulses spaced 3 cycles apart.
